// File: rtl/sram_dp_param.sv
// rtl/sram_dp_param.sv - parametrised simple-dual-port SRAM with byte mask, read latency and bulk clear
module sram_dp_param #(
  parameter int DATA_W   = 128,
  parameter int DEPTH    = 2048,
  parameter int ADDR_W   = 11,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  CEN,
  input  logic                  REN,
  input  logic                  WEN,
  input  logic [ADDR_W-1:0]     A1,
  input  logic [ADDR_W-1:0]     A2,
  input  logic [DATA_W-1:0]     D,
  input  logic [DATA_W/8-1:0]   BWEN,
  input  logic                  CLR,
  output logic [DATA_W-1:0]     Q,
  output logic                  QVALID,
  output logic                  BUSY
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_IDLE, S_CLEARING} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                rd_acc;
  logic                wr_acc;
  logic                a1_ok;
  logic                a2_ok;
  logic [DATA_W-1:0]   wr_word;
  logic [DATA_W-1:0]   rd_word;

  assign rd_acc = !CEN && !REN && !BUSY;
  assign wr_acc = !CEN && !WEN && !BUSY;
  assign a1_ok  = {1'b0, A1} < DEPTH_W;
  assign a2_ok  = {1'b0, A2} < DEPTH_W;

  // wr_word is the full post-merge word, so it doubles as the bypass value for new-data reads
  always_comb begin
    wr_word = a2_ok ? mem[A2] : '0;
    for (int i = 0; i < NB; i++) begin
      if (!BWEN[i]) wr_word[8*i +: 8] = D[8*i +: 8];
    end
    rd_word = '0;
    if (a1_ok) begin
      if ((RDW_MODE == 1) && wr_acc && a2_ok && (A1 == A2)) rd_word = wr_word;
      else                                                   rd_word = mem[A1];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      clr_cnt <= '0;
      BUSY    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (CLR) begin
            state   <= S_CLEARING;
            clr_cnt <= '0;
            BUSY    <= 1'b1;
          end
        end
        S_CLEARING: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST) begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

  // Contents are deliberately not reset; port writes are blocked while clearing via BUSY
  always_ff @(posedge CLK) begin
    if (state == S_CLEARING)    mem[clr_cnt] <= '0;
    else if (wr_acc && a2_ok)   mem[A2]      <= wr_word;
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              s1_vld;
      logic [DATA_W-1:0] s1_data;

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          s1_vld  <= 1'b0;
          s1_data <= '0;
          Q       <= '0;
          QVALID  <= 1'b0;
        end else begin
          s1_vld <= rd_acc;
          if (rd_acc) s1_data <= rd_word;
          QVALID <= s1_vld;
          if (s1_vld) Q <= s1_data;
        end
      end
    end else begin : g_lat1
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          Q      <= '0;
          QVALID <= 1'b0;
        end else begin
          QVALID <= rd_acc;
          if (rd_acc) Q <= rd_word;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sram_dp_param.sv
// tb/tb_sram_dp_param.sv - two differently parametrised instances checked against an array-based reference
module tb_sram_dp_param;

  logic        clk = 1'b0;
  logic        rst_n, cen, ren, wen, clr;
  logic [4:0]  a1, a2;
  logic [31:0] d;
  logic [3:0]  bwen;
  logic [31:0] q_o [2];
  logic        qv_o [2];
  logic        busy_o [2];

  always #5 clk = ~clk;

  // dut 0: power-of-2 depth, latency 1, old-data RDW; dut 1: depth 20, latency 2, new-data RDW
  sram_dp_param #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .RD_LAT(1), .RDW_MODE(0)) u_dut0 (
    .CLK(clk), .RST_N(rst_n), .CEN(cen), .REN(ren), .WEN(wen), .A1(a1), .A2(a2), .D(d),
    .BWEN(bwen), .CLR(clr), .Q(q_o[0]), .QVALID(qv_o[0]), .BUSY(busy_o[0]));

  sram_dp_param #(.DATA_W(32), .DEPTH(20), .ADDR_W(5), .RD_LAT(2), .RDW_MODE(1)) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .CEN(cen), .REN(ren), .WEN(wen), .A1(a1), .A2(a2), .D(d),
    .BWEN(bwen), .CLR(clr), .Q(q_o[1]), .QVALID(qv_o[1]), .BUSY(busy_o[1]));

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  typedef struct {
    int          dut;
    int          due;
    logic [31:0] data;
  } exp_t;

  logic [31:0] mm [2][32];
  bit          busy_m [2];
  int          cnt_m [2];
  logic [31:0] lastq [2];
  int          cyc;
  exp_t        eq [$];

  function automatic int dep_of(input int k);
    return (k == 0) ? 32 : 20;
  endfunction

  task automatic model_edge();
    int          dep;
    bit          rd, wr;
    logic [31:0] nw, rdata;
    cyc++;
    if (!rst_n) return;
    for (int k = 0; k < 2; k++) begin
      dep = dep_of(k);
      rd  = !cen && !ren && !busy_m[k];
      wr  = !cen && !wen && !busy_m[k];
      nw  = (int'(a2) < dep) ? mm[k][a2] : '0;
      for (int b = 0; b < 4; b++) if (!bwen[b]) nw[8*b +: 8] = d[8*b +: 8];
      rdata = (int'(a1) < dep) ? mm[k][a1] : '0;
      if (k == 1 && wr && a1 == a2 && int'(a1) < dep) rdata = nw;
      if (busy_m[k]) begin
        mm[k][cnt_m[k]] = '0;
        cnt_m[k]++;
        if (cnt_m[k] == dep) busy_m[k] = 1'b0;
      end else if (clr) begin
        busy_m[k] = 1'b1;
        cnt_m[k]  = 0;
      end
      if (wr && int'(a2) < dep) mm[k][a2] = nw;
      if (rd) eq.push_back('{k, cyc + k, rdata});
    end
  endtask

  task automatic check_all();
    bit ev;
    for (int k = 0; k < 2; k++) begin
      ev = 1'b0;
      foreach (eq[i]) begin
        if (eq[i].dut == k && eq[i].due == cyc) begin
          ev       = 1'b1;
          lastq[k] = eq[i].data;
        end
      end
      check_eq($sformatf("qvalid%0d@%0d", k, cyc), 32'(qv_o[k]), 32'(ev));
      check_eq($sformatf("q%0d@%0d", k, cyc), q_o[k], lastq[k]);
      check_eq($sformatf("busy%0d@%0d", k, cyc), 32'(busy_o[k]), 32'(busy_m[k]));
    end
    while (eq.size() > 0 && eq[0].due <= cyc) void'(eq.pop_front());
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    cen = 1'b1; ren = 1'b1; wen = 1'b1; clr = 1'b0; bwen = '1;
  endtask

  task automatic do_idle();
    idle();
    step();
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] v, input logic [3:0] m);
    cen = 1'b0; ren = 1'b1; wen = 1'b0; clr = 1'b0; a2 = a; d = v; bwen = m;
    step();
  endtask

  task automatic do_read(input logic [4:0] a);
    cen = 1'b0; ren = 1'b0; wen = 1'b1; clr = 1'b0; a1 = a; bwen = '1;
    step();
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    busy_m = '{1'b0, 1'b0};
    lastq  = '{32'h0, 32'h0};
    eq.delete();
    check_all();
    do_idle();
    rst_n = 1'b1;
  endtask

  int bc0, bc1, pc0, pc1;
  logic [4:0] n;

  initial begin
    for (int k = 0; k < 2; k++) for (int i = 0; i < 32; i++) mm[k][i] = '0;
    busy_m = '{1'b0, 1'b0};
    cnt_m  = '{0, 0};
    lastq  = '{32'h0, 32'h0};
    cyc    = 0;
    rst_n  = 1'b0;
    a1 = '0; a2 = '0; d = '0;
    idle();
    step();
    step();
    rst_n = 1'b1;

    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (33) step();

    do_write(5'd5, 32'hA5A5A5A5, 4'b0000);
    do_read(5'd5);
    check_eq("t1_qv_lat1", 32'(qv_o[0]), 32'd1);
    check_eq("t1_q_lat1", q_o[0], 32'hA5A5A5A5);
    check_eq("t1_qv_lat2_early", 32'(qv_o[1]), 32'd0);
    do_idle();
    check_eq("t1_qv_lat2", 32'(qv_o[1]), 32'd1);
    check_eq("t1_q_lat2", q_o[1], 32'hA5A5A5A5);
    check_eq("t1_qv_lat1_drop", 32'(qv_o[0]), 32'd0);

    do_write(5'd7, 32'hFFFFFFFF, 4'b0000);
    do_write(5'd7, 32'h00000000, 4'b1110);
    do_read(5'd7);
    check_eq("t2_mask_lat1", q_o[0], 32'hFFFFFF00);
    do_idle();
    check_eq("t2_mask_lat2", q_o[1], 32'hFFFFFF00);

    do_write(5'd3, 32'h11223344, 4'b0000);
    cen = 1'b0; ren = 1'b0; wen = 1'b0; a1 = 5'd3; a2 = 5'd3; d = 32'h55667788; bwen = 4'b0000;
    step();
    check_eq("t3_rdw_old", q_o[0], 32'h11223344);
    do_idle();
    check_eq("t3_rdw_new", q_o[1], 32'h55667788);

    idle();
    clr = 1'b1;
    step();
    bc0 = int'(busy_o[0]);
    bc1 = int'(busy_o[1]);
    for (int i = 0; i < 40; i++) begin
      idle();
      if (i < 15) begin
        cen = 1'b0; wen = 1'($urandom % 2); a2 = 5'($urandom); d = $urandom; bwen = 4'b0000;
      end
      step();
      bc0 += int'(busy_o[0]);
      bc1 += int'(busy_o[1]);
    end
    check_eq("t4_busy_len0", 32'(bc0), 32'd32);
    check_eq("t4_busy_len1", 32'(bc1), 32'd20);
    for (int i = 0; i < 32; i++) begin
      do_read(5'(i));
      check_eq($sformatf("t4_zero%0d", i), q_o[0], 32'h0);
    end
    do_idle();
    do_idle();

    for (int i = 0; i < 32; i++) do_write(5'(i), 32'h01010101 * 32'(i + 1), 4'b0000);
    idle();
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (16) step();
    async_reset();
    for (int i = 0; i < 32; i++) begin
      do_read(5'(i));
      if (i == 5)  check_eq("t5_low_cleared", q_o[0], 32'h0);
      if (i == 20) check_eq("t5_high_kept", q_o[0], 32'h15151515);
    end
    do_idle();
    do_idle();

    n = '0; pc0 = 0; pc1 = 0;
    for (int i = 0; i < 18; i++) begin
      if (i < 16 && i != 8) begin
        do_read(n);
        n = n + 5'd1;
      end else begin
        do_idle();
      end
      pc0 += int'(qv_o[0]);
      pc1 += int'(qv_o[1]);
    end
    check_eq("t6_pulses0", 32'(pc0), 32'd15);
    check_eq("t6_pulses1", 32'(pc1), 32'd15);

    repeat (600) begin
      cen  = ($urandom % 8) == 0;
      ren  = 1'($urandom % 2);
      wen  = 1'($urandom % 2);
      a1   = 5'($urandom);
      a2   = ($urandom % 3 == 0) ? a1 : 5'($urandom);
      d    = $urandom;
      bwen = 4'($urandom);
      clr  = ($urandom % 100) == 0;
      step();
    end
    repeat (3) do_idle();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
